// File: rtl/updown_tick_counter.sv
// Up/down/hold counter stepped by rising edges of a divided-clock level input.
// Wraps or saturates at 0 and MAX_VAL, and emits registered step and terminal-count pulses.
module updown_tick_counter #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 9
) (
  input  logic             updown_tick_counter_fsys,
  input  logic             updown_tick_counter_rstn,
  input  logic             updown_tick_counter_tick,
  input  logic             updown_tick_counter_en,
  input  logic             updown_tick_counter_dir,
  input  logic             updown_tick_counter_wrap,
  input  logic             updown_tick_counter_load,
  input  logic [WIDTH-1:0] updown_tick_counter_load_val,
  output logic [WIDTH-1:0] updown_tick_counter_count,
  output logic [1:0]       updown_tick_counter_state,
  output logic             updown_tick_counter_step,
  output logic             updown_tick_counter_tc
);

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] count_reg, count_next;
  logic             step_reg, step_next;
  logic             tc_reg, tc_next;
  logic             tick_prev_reg;
  logic             rise;

  assign rise = updown_tick_counter_tick & ~tick_prev_reg;

  always_comb begin
    state_next = HOLD;
    if (updown_tick_counter_en)
      state_next = updown_tick_counter_dir ? UP : DOWN;
  end

  // Steps act on the registered state, so en/dir take effect one cycle late.
  always_comb begin
    count_next = count_reg;
    step_next  = 1'b0;
    tc_next    = 1'b0;
    if (updown_tick_counter_load) begin
      count_next = (updown_tick_counter_load_val > MAX_CNT) ? MAX_CNT
                                                             : updown_tick_counter_load_val;
    end else if (rise) begin
      case (state_reg)
        UP: begin
          if (count_reg < MAX_CNT) begin
            count_next = count_reg + ONE;
            step_next  = 1'b1;
          end else begin
            tc_next = 1'b1;
            if (updown_tick_counter_wrap) begin
              count_next = '0;
              step_next  = 1'b1;
            end
          end
        end
        DOWN: begin
          if (count_reg != '0) begin
            count_next = count_reg - ONE;
            step_next  = 1'b1;
          end else begin
            tc_next = 1'b1;
            if (updown_tick_counter_wrap) begin
              count_next = MAX_CNT;
              step_next  = 1'b1;
            end
          end
        end
        default: begin
          count_next = count_reg;
        end
      endcase
    end
  end

  // tick_prev resets high so a tick already asserted at reset exit is ignored.
  always_ff @(posedge updown_tick_counter_fsys) begin
    if (!updown_tick_counter_rstn) begin
      state_reg     <= HOLD;
      count_reg     <= '0;
      step_reg      <= 1'b0;
      tc_reg        <= 1'b0;
      tick_prev_reg <= 1'b1;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      step_reg      <= step_next;
      tc_reg        <= tc_next;
      tick_prev_reg <= updown_tick_counter_tick;
    end
  end

  assign updown_tick_counter_count = count_reg;
  assign updown_tick_counter_state = state_reg;
  assign updown_tick_counter_step  = step_reg;
  assign updown_tick_counter_tc    = tc_reg;

endmodule

// File: tb/tb_updown_tick_counter.sv
// Directed bench for updown_tick_counter: counting, limits, reset-exit tick, load priority, direction, reset.
module tb_updown_tick_counter;

  logic       fsys = 1'b0;
  logic       rstn;
  logic       tick;
  logic       en;
  logic       dir;
  logic       wrap;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic [1:0] state;
  logic       step;
  logic       tc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 fsys = ~fsys;

  updown_tick_counter #(.WIDTH(4), .MAX_VAL(9)) dut (
    .updown_tick_counter_fsys     (fsys),
    .updown_tick_counter_rstn     (rstn),
    .updown_tick_counter_tick     (tick),
    .updown_tick_counter_en       (en),
    .updown_tick_counter_dir      (dir),
    .updown_tick_counter_wrap     (wrap),
    .updown_tick_counter_load     (load),
    .updown_tick_counter_load_val (load_val),
    .updown_tick_counter_count    (count),
    .updown_tick_counter_state    (state),
    .updown_tick_counter_step     (step),
    .updown_tick_counter_tc       (tc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the edge.
  task automatic cyc();
    @(posedge fsys);
    #1;
  endtask

  // One tick pulse: high 3 cycles, low 3 cycles; counts step/tc pulses across it.
  task automatic do_rise(input string tag, input int exp_count, input int exp_steps, input int exp_tcs);
    int steps = 0;
    int tcs   = 0;
    tick = 1'b1;
    cyc();
    check({tag, " count"}, count, exp_count);
    for (int i = 0; i < 6; i++) begin
      if (i == 3) tick = 1'b0;
      if (i > 0) cyc();
      steps += int'(step);
      tcs   += int'(tc);
    end
    check({tag, " steps"}, steps, exp_steps);
    check({tag, " tcs"}, tcs, exp_tcs);
    $display("%s: count=%0d state=%0d steps=%0d tcs=%0d", tag, count, state, steps, tcs);
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1;
    load_val = v;
    cyc();
    load = 1'b0;
    $display("load %0d: count=%0d", v, count);
  endtask

  initial begin
    int exp_c;
    int steps;
    rstn = 1'b0; tick = 1'b0; en = 1'b1; dir = 1'b1; wrap = 1'b1;
    load = 1'b0; load_val = '0;
    #1;
    cyc(); cyc();
    check("rst count", count, 0);
    check("rst state", state, 0);
    check("rst step", step, 0);
    check("rst tc", tc, 0);
    $display("reset: count=%0d state=%0d", count, state);

    // 1: wrap-around up counting
    rstn = 1'b1;
    cyc(); cyc();
    check("t1 state up", state, 1);
    for (int r = 1; r <= 12; r++) begin
      exp_c = r % 10;
      do_rise($sformatf("t1 rise%0d", r), exp_c, 1, (r == 10) ? 1 : 0);
    end

    // 2: saturate then wrap at zero going down
    dir = 1'b0; wrap = 1'b0;
    do_load(4'd0);
    check("t2 state down", state, 2);
    do_rise("t2 sat1", 0, 0, 1);
    do_rise("t2 sat2", 0, 0, 1);
    wrap = 1'b1;
    do_rise("t2 wrap", 9, 1, 1);

    // 3: tick high through reset exit is not counted
    rstn = 1'b0; tick = 1'b1; dir = 1'b1;
    cyc(); cyc();
    rstn = 1'b1;
    steps = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      steps += int'(step);
    end
    check("t3 held count", count, 0);
    check("t3 held steps", steps, 0);
    tick = 1'b0;
    cyc(); cyc();
    do_rise("t3 rise", 1, 1, 0);

    // 4: load beats a simultaneous rise, and is clamped
    do_load(4'd5);
    check("t4 count5", count, 5);
    load = 1'b1; load_val = 4'd12; tick = 1'b1;
    cyc();
    load = 1'b0;
    check("t4 clamp count", count, 9);
    check("t4 step", step, 0);
    check("t4 tc", tc, 0);
    cyc();
    check("t4 no incr", count, 9);
    check("t4 no step", step, 0);
    tick = 1'b0;
    cyc(); cyc();

    // 5: direction change and hold
    do_load(4'd4);
    check("t5 state up", state, 1);
    dir = 1'b0;
    cyc();
    check("t5 state down", state, 2);
    do_rise("t5 down", 3, 1, 0);
    en = 1'b0;
    cyc();
    check("t5 state hold", state, 0);
    do_rise("t5 hold1", 3, 0, 0);
    do_rise("t5 hold2", 3, 0, 0);

    // 6: reset wins over a rise
    en = 1'b1; dir = 1'b1;
    do_load(4'd7);
    cyc();
    check("t6 count7", count, 7);
    rstn = 1'b0; tick = 1'b1;
    cyc();
    check("t6 count", count, 0);
    check("t6 state", state, 0);
    check("t6 step", step, 0);
    check("t6 tc", tc, 0);
    rstn = 1'b1; tick = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/updown_tick_counter.md
Name: updown_tick_counter

Overview:
- Downstream consumer of the clock-divider output in the counter-with-direction-control design.
- Runs on the system clock and treats the divided clock as a level input, never as a clock. Each rising edge of that level is one count step.
- A 3-state direction FSM selects up, down or hold. Supports synchronous load, wrap or saturate at limits, and terminal-count and step pulses for display and LED logic.

Parameters:
WIDTH, 4, count register width in bits
MAX_VAL, 9, highest legal count value; must be less than 2^WIDTH (default gives a 0..9 decade counter)

Ports:
updown_tick_counter_fsys  input  1  system clock; all logic is on its rising edge
updown_tick_counter_rstn  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
updown_tick_counter_tick  input  1  divided-clock level from the clock divider
updown_tick_counter_en  input  1  1 = counting allowed
updown_tick_counter_dir  input  1  1 = up, 0 = down
updown_tick_counter_wrap  input  1  1 = wrap at limits, 0 = saturate at limits
updown_tick_counter_load  input  1  synchronous load strobe
updown_tick_counter_load_val  input  WIDTH  value to load
updown_tick_counter_count  output  WIDTH  current count
updown_tick_counter_state  output  2  FSM state: 00 HOLD, 01 UP, 10 DOWN
updown_tick_counter_step  output  1  1-cycle pulse on every accepted step
updown_tick_counter_tc  output  1  1-cycle pulse when a step hits a limit

Behaviour:
- Reset (rstn=0 sampled at an edge):
  - count=0, state=HOLD, step=0, tc=0.
  - tick_prev register set to 1, so a tick already high at reset exit is not counted.
  - Reset overrides load and any step in progress.
- Edge detect: rise = tick & ~tick_prev; tick_prev <= tick every cycle. A tick held high for many cycles yields exactly one rise.
- FSM (registered, updated every cycle from en/dir):
  - en=0 -> HOLD.
  - en=1, dir=1 -> UP.
  - en=1, dir=0 -> DOWN.
  - All transitions are legal in one cycle, including UP <-> DOWN directly.
  - Step decisions use the registered state, so en/dir changes take effect 1 cycle after they are sampled.
  - Encoding 11 is unreachable; if entered, it behaves as HOLD and goes to the decoded state next cycle.
- Priority per edge: reset > load > step.
- Load:
  - count <= min(load_val, MAX_VAL).
  - step=0, tc=0.
  - A rise in the same cycle is consumed and discarded.
- Step (rise=1, no load):
  - HOLD: count unchanged, step=0, tc=0.
  - UP, count<MAX_VAL: count+1, step=1.
  - UP, count==MAX_VAL: wrap=1 -> count=0, step=1, tc=1; wrap=0 -> count held, step=0, tc=1.
  - DOWN, count>0: count-1, step=1.
  - DOWN, count==0: wrap=1 -> count=MAX_VAL, step=1, tc=1; wrap=0 -> count held, step=0, tc=1.
  - Count is never outside 0..MAX_VAL. Arithmetic is WIDTH-bit; limit compares are against MAX_VAL, not 2^WIDTH-1.
- Latency:
  - The count changes at the first fsys edge at which tick is sampled 1 after being sampled 0.
  - step and tc are registered and asserted in the cycle the new count is visible; both deassert on the next cycle.
- wrap is sampled at the step edge only; changing it between steps has no other effect.

Test Plan:
1. Reset, then hold rstn=1, en=1, dir=1, wrap=1. Apply 12 tick rises, each tick high 3 cycles and low 3 cycles -> count goes 1..9, 0, 1, 2. tc pulses exactly once, on the 9->0 step. Exactly one step pulse per rise.
2. With count=0, DOWN, wrap=0, apply 2 rises -> count stays 0, tc pulses twice, step stays 0. Then set wrap=1 and apply 1 rise -> count=9, tc=1, step=1.
3. Hold tick=1 through reset release, en=1, dir=1 -> count stays 0 until tick goes low then high again.
4. With count=5, assert load with load_val=12 in the same cycle as a tick rise -> count=9, step=0, tc=0, and no increment on the following cycle.
5. With count=4, UP, change dir to 0 one cycle before a rise -> state goes 01->10 and count=3. Set en=0 -> state=00, and further rises leave count=3.
6. Assert rstn=0 for 1 cycle in the same cycle as a rise while count=7 -> count=0, state=00, step=0, tc=0 on that edge.
